// File: rtl/rf_clk_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// rf_clk_pkg : shared types and config legality check for rf_clkdiv_bank
// Rev 1.0
// ------------------------------------------------------------------
package rf_clk_pkg;

  localparam int CFG_W = 8;

  typedef enum logic [1:0] {
    ALIGN  = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_t;

  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] high;
    logic [CFG_W-1:0] phase;
  } chan_cfg_t;

  // high < div and phase < div keep every channel counter inside 0..div-1
  function automatic logic cfg_legal(input logic [31:0] ch,
                                     input logic [31:0] num_ch,
                                     input chan_cfg_t   c);
    return (ch < num_ch) && (c.div >= CFG_W'(2)) && (c.high != '0) &&
           (c.high < c.div) && (c.phase < c.div);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_clkdiv_chan.sv
`default_nettype none
// ------------------------------------------------------------------
// rf_clkdiv_chan : one divided-clock channel (counter, outclk, rise strobe)
// Rev 1.0
// ------------------------------------------------------------------
module rf_clkdiv_chan
  import rf_clk_pkg::*;
(
  input  logic      refclk,
  input  logic      rst,
  input  chan_cfg_t cfg_i,
  input  logic      align_i,
  output logic      outclk_o,
  output logic      outclk_stb_o
);

  logic [CFG_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             stb_q, stb_d;

  always_comb begin
    cnt_d = (cnt_q == cfg_i.div - CFG_W'(1)) ? '0 : cnt_q + CFG_W'(1);
    clk_d = (cnt_q < cfg_i.high);
    stb_d = clk_d && !clk_q;
    // Preloading div-phase makes the counter reach 0 exactly phase cycles late
    if (align_i) begin
      cnt_d = (cfg_i.phase == '0) ? '0 : cfg_i.div - cfg_i.phase;
      clk_d = 1'b0;
      stb_d = 1'b0;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
      stb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
      stb_q <= stb_d;
    end
  end

  assign outclk_o     = clk_q;
  assign outclk_stb_o = stb_q;

endmodule
`default_nettype wire

// File: rtl/rf_clkdiv_bank.sv
`default_nettype none
// ------------------------------------------------------------------
// rf_clkdiv_bank : multi-channel programmable clock divider with common re-align and lock
// Rev 1.0
// ------------------------------------------------------------------
module rf_clkdiv_bank
  import rf_clk_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = CFG_W,
  parameter int DEF_DIV     = 8,
  parameter int DEF_HIGH    = 4,
  parameter int LOCK_CYCLES = 16,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [DIV_W-1:0]  cfg_div_i,
  input  logic [DIV_W-1:0]  cfg_high_i,
  input  logic [DIV_W-1:0]  cfg_phase_i,
  output logic              cfg_err_o,
  input  logic              sync_req_i,
  output logic [NUM_CH-1:0] outclk_o,
  output logic [NUM_CH-1:0] outclk_stb_o,
  output logic              locked_o
);

  localparam int        LC_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam chan_cfg_t DEF_CFG = '{div: CFG_W'(DEF_DIV), high: CFG_W'(DEF_HIGH), phase: '0};

  state_t          state_q, state_d;
  logic [LC_W-1:0] lock_cnt_q, lock_cnt_d;
  logic            err_q;
  chan_cfg_t       shadow_q [NUM_CH];
  chan_cfg_t       active_q [NUM_CH];
  chan_cfg_t       wr_cfg;
  logic            wr_fire, wr_legal, align;

  assign align       = (state_q == ALIGN);
  assign cfg_ready_o = !align;
  assign locked_o    = (state_q == LOCKED);
  assign cfg_err_o   = err_q;
  assign wr_cfg      = '{div: cfg_div_i, high: cfg_high_i, phase: cfg_phase_i};
  assign wr_fire     = cfg_valid_i && cfg_ready_o;
  assign wr_legal    = cfg_legal(32'(cfg_ch_i), 32'(NUM_CH), wr_cfg);

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      ALIGN: begin
        state_d    = SETTLE;
        lock_cnt_d = '0;
      end
      SETTLE: begin
        if (sync_req_i)                                  state_d = ALIGN;
        else if (lock_cnt_q == LC_W'(LOCK_CYCLES - 1))   state_d = LOCKED;
        else                                             lock_cnt_d = lock_cnt_q + LC_W'(1);
      end
      LOCKED: begin
        if (sync_req_i) state_d = ALIGN;
      end
      default: state_d = ALIGN;
    endcase
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q    <= ALIGN;
      lock_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      err_q      <= wr_fire && !wr_legal;
    end
  end

  // A write landing with sync_req updates the shadow in time for the following ALIGN
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= DEF_CFG;
        active_q[i] <= DEF_CFG;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_fire && wr_legal && (int'(cfg_ch_i) == i)) shadow_q[i] <= wr_cfg;
        if (align) active_q[i] <= shadow_q[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    rf_clkdiv_chan u_chan (
      .refclk       (refclk),
      .rst          (rst),
      .cfg_i        (align ? shadow_q[g] : active_q[g]),
      .align_i      (align),
      .outclk_o     (outclk_o[g]),
      .outclk_stb_o (outclk_stb_o[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_clkdiv_bank.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_rf_clkdiv_bank : directed self-checking bench for rf_clkdiv_bank
// Rev 1.0
// ------------------------------------------------------------------
module tb_rf_clkdiv_bank;

  localparam int NUM_CH = 3;
  localparam int DIV_W  = 8;
  localparam int LOCK   = 16;
  localparam int CH_W   = 2;
  localparam int MAXS   = 128;

  logic              refclk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_valid = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [DIV_W-1:0]  cfg_div = '0, cfg_high = '0, cfg_phase = '0;
  logic              sync_req = 1'b0;
  logic              cfg_ready, cfg_err, locked;
  logic [NUM_CH-1:0] outclk, outclk_stb;

  int n_checks = 0;
  int n_errors = 0;

  logic [NUM_CH-1:0] log_oc  [MAXS];
  logic [NUM_CH-1:0] log_st  [MAXS];
  logic              log_lk  [MAXS];
  logic              log_rdy [MAXS];
  logic              log_err [MAXS];

  always #5 refclk = ~refclk;

  rf_clkdiv_bank #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEF_DIV(8), .DEF_HIGH(4), .LOCK_CYCLES(LOCK)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .cfg_valid_i  (cfg_valid),
    .cfg_ready_o  (cfg_ready),
    .cfg_ch_i     (cfg_ch),
    .cfg_div_i    (cfg_div),
    .cfg_high_i   (cfg_high),
    .cfg_phase_i  (cfg_phase),
    .cfg_err_o    (cfg_err),
    .sync_req_i   (sync_req),
    .outclk_o     (outclk),
    .outclk_stb_o (outclk_stb),
    .locked_o     (locked)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sample(input int idx);
    log_oc[idx]  = outclk;
    log_st[idx]  = outclk_stb;
    log_lk[idx]  = locked;
    log_rdy[idx] = cfg_ready;
    log_err[idx] = cfg_err;
  endtask

  // Log k negedge samples; requests driven before the call last one edge.
  // A second sync is raised after sample 'resync' when resync > 0.
  task automatic capture(input int k, input int resync);
    sample(0);
    for (int idx = 1; idx <= k; idx++) begin
      @(negedge refclk);
      sample(idx);
      if (idx == 1) begin
        cfg_valid = 1'b0;
        sync_req  = 1'b0;
      end
      if (resync > 0 && idx == resync)     sync_req = 1'b1;
      if (resync > 0 && idx == resync + 1) sync_req = 1'b0;
    end
  endtask

  function automatic void analyze(input int c, input int start, input int k,
                                  output int first, output int period, output int high,
                                  output int nstb, output int bad);
    logic prev, rise;
    first = -1; period = -1; high = 0; nstb = 0; bad = 0;
    prev = log_oc[start][c];
    for (int i = start + 1; i <= k; i++) begin
      rise = log_oc[i][c] && !prev;
      if (rise) begin
        if (first < 0)       first = i;
        else if (period < 0) period = i - first;
      end
      if (log_st[i][c] !== rise) bad++;
      if (log_st[i][c]) nstb++;
      prev = log_oc[i][c];
    end
    if (first > 0)
      for (int i = first; i <= k && log_oc[i][c]; i++) high++;
  endfunction

  function automatic int first_lock(input int k);
    for (int i = 1; i <= k; i++) if (log_lk[i]) return i;
    return -1;
  endfunction

  function automatic int count_ones_lk(input int k);
    int n = 0;
    for (int i = 1; i <= k; i++) if (log_lk[i]) n++;
    return n;
  endfunction

  function automatic int count_rdy_low(input int k);
    int n = 0;
    for (int i = 1; i <= k; i++) if (!log_rdy[i]) n++;
    return n;
  endfunction

  function automatic int count_err(input int k);
    int n = 0;
    for (int i = 1; i <= k; i++) if (log_err[i]) n++;
    return n;
  endfunction

  task automatic write_cfg(input int ch, input int dv, input int hi, input int ph);
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_div   = DIV_W'(dv);
    cfg_high  = DIV_W'(hi);
    cfg_phase = DIV_W'(ph);
    @(negedge refclk);
    cfg_valid = 1'b0;
  endtask

  // Default config after reset release: all channels /8, 4 high, coincident
  task automatic check_defaults(input string t);
    int f, p, h, n, b;
    for (int c = 0; c < NUM_CH; c++) begin
      analyze(c, 1, 40, f, p, h, n, b);
      check($sformatf("%s_ch%0d_first", t, c), f, 2);
      check($sformatf("%s_ch%0d_period", t, c), p, 8);
      check($sformatf("%s_ch%0d_high", t, c), h, 4);
      check($sformatf("%s_ch%0d_nstb", t, c), n, 5);
      check($sformatf("%s_ch%0d_stb_align", t, c), b, 0);
    end
    check({t, "_lock_first"}, first_lock(40), LOCK + 1);
    check({t, "_lock_ones"}, count_ones_lk(40), 40 - LOCK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f, p, h, n, b, f0, found;
    int ill_ch [3] = '{0, NUM_CH, 0};
    int ill_dv [3] = '{1, 8, 6};
    int ill_hi [3] = '{1, 4, 6};

    // Reset values
    repeat (3) @(negedge refclk);
    check("rst_outclk", 32'(outclk), 0);
    check("rst_stb", 32'(outclk_stb), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_ready", 32'(cfg_ready), 0);
    check("rst_err", 32'(cfg_err), 0);

    // 1: defaults after release
    rst = 1'b0;
    capture(40, 0);
    check_defaults("t1");

    // 2: phase-offset channel; write alone changes nothing visible
    write_cfg(1, 5, 2, 3);
    check("t2_err", 32'(cfg_err), 0);
    check("t2_lock_hold", 32'(locked), 1);
    capture(20, 0);
    analyze(1, 0, 20, f, p, h, n, b);
    check("t2_pre_ch1_period", p, 8);
    check("t2_pre_lock", count_ones_lk(20), 20);
    sync_req = 1'b1;
    capture(40, 0);
    analyze(0, 2, 40, f0, p, h, n, b);
    check("t2_ch0_first", f0, 3);
    check("t2_ch0_period", p, 8);
    check("t2_ch0_nstb", n, 5);
    analyze(1, 2, 40, f, p, h, n, b);
    check("t2_ch1_first", f, 6);
    check("t2_ch1_offset", f - f0, 3);
    check("t2_ch1_period", p, 5);
    check("t2_ch1_high", h, 2);
    check("t2_ch1_nstb", n, 7);
    check("t2_ch1_stb_align", b, 0);
    analyze(2, 2, 40, f, p, h, n, b);
    check("t2_ch2_first", f, 3);
    check("t2_lock_first", first_lock(40), LOCK + 2);
    check("t2_rdy_low", count_rdy_low(40), 1);
    check("t2_rdy_align", 32'(log_rdy[1]), 0);

    // 3: illegal writes are discarded and flagged once each
    for (int v = 0; v < 3; v++) begin
      write_cfg(ill_ch[v], ill_dv[v], ill_hi[v], 0);
      check($sformatf("t3_v%0d_err", v), 32'(cfg_err), 1);
      @(negedge refclk);
      check($sformatf("t3_v%0d_err_clr", v), 32'(cfg_err), 0);
      check($sformatf("t3_v%0d_lock", v), 32'(locked), 1);
    end
    sync_req = 1'b1;
    capture(40, 0);
    analyze(0, 2, 40, f, p, h, n, b);
    check("t3_ch0_first", f, 3);
    check("t3_ch0_period", p, 8);
    check("t3_ch0_high", h, 4);
    check("t3_err_quiet", count_err(40), 0);

    // 4: re-sync during SETTLE restarts the lock count
    sync_req = 1'b1;
    capture(40, 6);
    check("t4_lock_first", first_lock(40), 7 + LOCK + 1);
    check("t4_lock_ones", count_ones_lk(40), 40 - (7 + LOCK));
    check("t4_rdy_low", count_rdy_low(40), 2);
    check("t4_rdy_align2", 32'(log_rdy[7]), 0);

    // 5: write in the same cycle as sync_req joins that alignment
    cfg_valid = 1'b1;
    cfg_ch    = 2'd2;
    cfg_div   = 8'd3;
    cfg_high  = 8'd1;
    cfg_phase = 8'd0;
    sync_req  = 1'b1;
    capture(40, 0);
    analyze(2, 2, 40, f, p, h, n, b);
    check("t5_ch2_first", f, 3);
    check("t5_ch2_period", p, 3);
    check("t5_ch2_high", h, 1);
    check("t5_ch2_stb_align", b, 0);
    analyze(0, 2, 40, f, p, h, n, b);
    check("t5_ch0_period", p, 8);
    check("t5_rdy_low", count_rdy_low(40), 1);
    check("t5_rdy_align", 32'(log_rdy[1]), 0);
    check("t5_err_quiet", count_err(40), 0);
    check("t5_lock_first", first_lock(40), LOCK + 2);

    // 6: asynchronous reset while ch0 is high
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge refclk);
      if (outclk[0]) found = 1;
    end
    check("t6_found_high", found, 1);
    #1 rst = 1'b1;
    #1;
    check("t6_async_outclk", 32'(outclk), 0);
    check("t6_async_stb", 32'(outclk_stb), 0);
    check("t6_async_locked", 32'(locked), 0);
    check("t6_async_ready", 32'(cfg_ready), 0);
    repeat (3) @(negedge refclk);
    check("t6_hold_outclk", 32'(outclk), 0);
    check("t6_hold_locked", 32'(locked), 0);
    rst = 1'b0;
    capture(40, 0);
    check_defaults("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
